// File: rtl/stq_wq_pkg.sv
// Shared store-queue package: array geometry and index/data typedefs used by
// the WQ allocator and its pointer sub-module.
package stq_wq_pkg;
    localparam int STQ_DEPTH = 64;
    localparam int STQ_WQW   = 6;
    localparam int STQ_ADW   = 5;

    typedef logic [STQ_WQW-1:0] wq_t;
    typedef logic [STQ_ADW-1:0] adata_t;
endpackage

// File: rtl/stq_wq_ptr.sv
// Modular ring pointer: advances by 0/1/2 with natural power-of-two wrap, or
// loads an absolute value (used for flush rollback of the tail).
module stq_wq_ptr
    import stq_wq_pkg::*;
#(
    parameter int W = STQ_WQW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   adv,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr,
    output logic [W-1:0] ptr_nxt
);
    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q + {{(W-2){1'b0}}, adv};
        if (load) ptr_d = load_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign ptr     = ptr_q;
    assign ptr_nxt = ptr_d;
endmodule

// File: rtl/stq_wq_alloc.sv
// Store-queue WQ slot allocator / retire tracker: 2-wide in-order allocation,
// 1-cycle registered array writes, 2-wide retire, flush rollback.
// Optional STQ_WQ_PARTIAL_FLUSH_EN: flush rolls the tail back to flush_WQ.
module stq_wq_alloc
    import stq_wq_pkg::*;
#(
    parameter int DEPTH = STQ_DEPTH,
    parameter int WQW   = STQ_WQW,
    parameter int ADW   = STQ_ADW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           alloc0_req,
    input  logic [ADW-1:0] alloc0_adata,
    input  logic           alloc1_req,
    input  logic [ADW-1:0] alloc1_adata,
    output logic           alloc_stall,
    output logic [WQW-1:0] alloc0_WQ,
    output logic [WQW-1:0] alloc1_WQ,
    output logic           wrt0_en,
    output logic           wrt1_en,
    output logic [WQW-1:0] wrt0_WQ,
    output logic [WQW-1:0] wrt1_WQ,
    output logic [ADW-1:0] wrt0_adata,
    output logic [ADW-1:0] wrt1_adata,
    input  logic [1:0]     retire_cnt,
    output logic [WQW-1:0] upd0_WQ,
    output logic [WQW-1:0] upd1_WQ,
    output logic           upd0_vld,
    output logic           upd1_vld,
    input  logic           flush,
`ifdef STQ_WQ_PARTIAL_FLUSH_EN
    input  logic [WQW-1:0] flush_WQ,
`endif
    output logic [WQW:0]   free_cnt,
    output logic           full,
    output logic           empty
);
    logic [WQW:0]   count_q, count_d;
    logic [WQW-1:0] head, head_nxt, tail, tail_nxt, tail_load;
    logic [1:0]     nreq, nalloc, ret_clamp, nret, tail_adv;

    logic           wrt0_en_q, wrt0_en_d, wrt1_en_q, wrt1_en_d;
    logic [WQW-1:0] wrt0_WQ_q, wrt0_WQ_d, wrt1_WQ_q, wrt1_WQ_d;
    logic [ADW-1:0] wrt0_adata_q, wrt0_adata_d, wrt1_adata_q, wrt1_adata_d;

`ifdef STQ_WQ_PARTIAL_FLUSH_EN
    assign tail_load = flush_WQ;
`else
    assign tail_load = head_nxt;
`endif

    always_comb begin
        free_cnt    = (WQW+1)'(DEPTH) - count_q;
        nreq        = {1'b0, alloc0_req} + {1'b0, alloc1_req};
        // Stall looks only at the registered count: no credit for same-cycle retire.
        alloc_stall = (WQW+1)'(nreq) > free_cnt;
        nalloc      = alloc_stall ? 2'd0 : nreq;
        ret_clamp   = retire_cnt[1] ? 2'd2 : retire_cnt;
        nret        = ((WQW+1)'(ret_clamp) > count_q) ? count_q[1:0] : ret_clamp;
        tail_adv    = flush ? 2'd0 : nalloc;
        alloc0_WQ   = tail;
        alloc1_WQ   = alloc0_req ? tail + WQW'(1) : tail;

        count_d = count_q + (WQW+1)'(nalloc) - (WQW+1)'(nret);
        if (flush) begin
`ifdef STQ_WQ_PARTIAL_FLUSH_EN
            count_d = {1'b0, flush_WQ - head_nxt};
`else
            count_d = '0;
`endif
        end

        // First granted store always lands on write port 0.
        wrt0_en_d    = !flush && (nalloc != 2'd0);
        wrt1_en_d    = !flush && (nalloc == 2'd2);
        wrt0_WQ_d    = tail;
        wrt1_WQ_d    = tail + WQW'(1);
        wrt0_adata_d = alloc0_req ? alloc0_adata : alloc1_adata;
        wrt1_adata_d = alloc1_adata;
    end

    stq_wq_ptr #(.W(WQW)) u_head (
        .clk(clk), .rst(rst), .adv(nret), .load(1'b0), .load_val('0),
        .ptr(head), .ptr_nxt(head_nxt)
    );

    stq_wq_ptr #(.W(WQW)) u_tail (
        .clk(clk), .rst(rst), .adv(tail_adv), .load(flush), .load_val(tail_load),
        .ptr(tail), .ptr_nxt(tail_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= '0;
            wrt0_en_q    <= 1'b0;
            wrt1_en_q    <= 1'b0;
            wrt0_WQ_q    <= '0;
            wrt1_WQ_q    <= '0;
            wrt0_adata_q <= '0;
            wrt1_adata_q <= '0;
        end else begin
            count_q      <= count_d;
            wrt0_en_q    <= wrt0_en_d;
            wrt1_en_q    <= wrt1_en_d;
            wrt0_WQ_q    <= wrt0_WQ_d;
            wrt1_WQ_q    <= wrt1_WQ_d;
            wrt0_adata_q <= wrt0_adata_d;
            wrt1_adata_q <= wrt1_adata_d;
        end
    end

    assign wrt0_en    = wrt0_en_q;
    assign wrt1_en    = wrt1_en_q;
    assign wrt0_WQ    = wrt0_WQ_q;
    assign wrt1_WQ    = wrt1_WQ_q;
    assign wrt0_adata = wrt0_adata_q;
    assign wrt1_adata = wrt1_adata_q;
    assign upd0_WQ    = head;
    assign upd1_WQ    = head + WQW'(1);
    assign upd0_vld   = count_q != '0;
    assign upd1_vld   = count_q > (WQW+1)'(1);
    assign full       = count_q == (WQW+1)'(DEPTH);
    assign empty      = count_q == '0;
endmodule

// File: tb/tb_stq_wq_alloc.sv
// Directed self-checking bench for stq_wq_alloc: allocation, compaction,
// stall at full, wrap, retire clamp, flush rollback and async reset.
module tb_stq_wq_alloc;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc0_req = 0, alloc1_req = 0, flush = 0;
    logic [4:0] alloc0_adata = 0, alloc1_adata = 0;
    logic [1:0] retire_cnt = 0;
    logic       alloc_stall, wrt0_en, wrt1_en, upd0_vld, upd1_vld, full, empty;
    logic [5:0] alloc0_WQ, alloc1_WQ, wrt0_WQ, wrt1_WQ, upd0_WQ, upd1_WQ;
    logic [4:0] wrt0_adata, wrt1_adata;
    logic [6:0] free_cnt;
`ifdef STQ_WQ_PARTIAL_FLUSH_EN
    logic [5:0] flush_WQ = 0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stq_wq_alloc dut (
        .clk(clk), .rst(rst),
        .alloc0_req(alloc0_req), .alloc0_adata(alloc0_adata),
        .alloc1_req(alloc1_req), .alloc1_adata(alloc1_adata),
        .alloc_stall(alloc_stall), .alloc0_WQ(alloc0_WQ), .alloc1_WQ(alloc1_WQ),
        .wrt0_en(wrt0_en), .wrt1_en(wrt1_en), .wrt0_WQ(wrt0_WQ), .wrt1_WQ(wrt1_WQ),
        .wrt0_adata(wrt0_adata), .wrt1_adata(wrt1_adata),
        .retire_cnt(retire_cnt), .upd0_WQ(upd0_WQ), .upd1_WQ(upd1_WQ),
        .upd0_vld(upd0_vld), .upd1_vld(upd1_vld), .flush(flush),
`ifdef STQ_WQ_PARTIAL_FLUSH_EN
        .flush_WQ(flush_WQ),
`endif
        .free_cnt(free_cnt), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc0_req = 0; alloc1_req = 0; retire_cnt = 0; flush = 0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_free", 32'(free_cnt), 64);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_vld", 32'({upd0_vld, upd1_vld}), 0);
        chk("rst_upd0", 32'(upd0_WQ), 0);
        chk("rst_upd1", 32'(upd1_WQ), 1);
        chk("rst_wen", 32'({wrt0_en, wrt1_en}), 0);
        #10 rst = 1;
        tick();

        // Dual allocation
        alloc0_req = 1; alloc0_adata = 5'h03; alloc1_req = 1; alloc1_adata = 5'h1C;
        #1;
        chk("dual_wq0", 32'(alloc0_WQ), 0);
        chk("dual_wq1", 32'(alloc1_WQ), 1);
        chk("dual_stall", 32'(alloc_stall), 0);
        tick(); idle(); #1;
        chk("dual_wen", 32'({wrt0_en, wrt1_en}), 3);
        chk("dual_wrtwq", 32'({wrt0_WQ, wrt1_WQ}), {6'd0, 6'd1});
        chk("dual_adata", 32'({wrt0_adata, wrt1_adata}), {5'h03, 5'h1C});
        chk("dual_free", 32'(free_cnt), 62);

        // Only store 1 requests: compacts onto tail and write port 0
        alloc1_req = 1; alloc1_adata = 5'h0A; #1;
        chk("solo1_wq", 32'(alloc1_WQ), 2);
        tick(); idle(); #1;
        chk("solo1_wen", 32'({wrt0_en, wrt1_en}), 2'b10);
        chk("solo1_wrtwq", 32'(wrt0_WQ), 2);
        chk("solo1_adata", 32'(wrt0_adata), 5'h0A);

        // Fill to 63 (count 3 + 60)
        alloc0_req = 1; alloc1_req = 1;
        repeat (30) tick();
        idle(); #1;
        chk("fill_free", 32'(free_cnt), 1);
        alloc0_req = 1; alloc1_req = 1; #1;
        chk("fill_stall2", 32'(alloc_stall), 1);
        tick(); idle(); #1;
        chk("fill_nowrite", 32'({wrt0_en, wrt1_en}), 0);
        chk("fill_free2", 32'(free_cnt), 1);
        alloc0_req = 1; alloc0_adata = 5'h15; #1;
        chk("last_stall", 32'(alloc_stall), 0);
        chk("last_wq", 32'(alloc0_WQ), 63);
        tick(); idle(); #1;
        chk("last_full", 32'(full), 1);
        chk("last_wen", 32'({wrt0_en, wrt1_en}), 2'b10);
        chk("last_wrtwq", 32'(wrt0_WQ), 63);

        // Full with simultaneous retire: stall uses pre-retire count
        alloc0_req = 1; alloc1_req = 1; retire_cnt = 2; #1;
        chk("fullret_stall", 32'(alloc_stall), 1);
        tick(); idle(); #1;
        chk("fullret_free", 32'(free_cnt), 2);
        chk("fullret_upd", 32'({upd0_WQ, upd1_WQ}), {6'd2, 6'd3});
        chk("fullret_nowrite", 32'(wrt0_en), 0);
        chk("fullret_notfull", 32'(full), 0);
        alloc0_req = 1; #1;
        chk("wrap_wq", 32'(alloc0_WQ), 0);
        tick(); idle(); // count 63, head 2, tail 1

        // Full flush to empty at head=2
`ifdef STQ_WQ_PARTIAL_FLUSH_EN
        flush_WQ = 6'd2;
`endif
        flush = 1;
        tick(); idle(); #1;
        chk("flush0_empty", 32'(empty), 1);
        chk("flush0_upd0", 32'(upd0_WQ), 2);
        // Build head=10, count=5
        alloc0_req = 1; alloc1_req = 1;
        repeat (4) tick();
        idle(); retire_cnt = 2;
        repeat (4) tick();
        idle(); alloc0_req = 1; alloc1_req = 1;
        repeat (2) tick();
        alloc1_req = 0;
        tick(); idle(); #1;
        chk("pre_flush_head", 32'(upd0_WQ), 10);
        chk("pre_flush_free", 32'(free_cnt), 59);

        // Flush + retire 1 + alloc: retire first, then roll tail to head
`ifdef STQ_WQ_PARTIAL_FLUSH_EN
        flush_WQ = 6'd11;
`endif
        flush = 1; retire_cnt = 1; alloc0_req = 1;
        tick(); idle(); #1;
        chk("flush_head", 32'(upd0_WQ), 11);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_free", 32'(free_cnt), 64);
        chk("flush_nowrite", 32'({wrt0_en, wrt1_en}), 0);
        alloc0_req = 1; #1;
        chk("flush_tail", 32'(alloc0_WQ), 11);
        tick(); idle(); // count 1

        // Retire 2 with count 1: clamps to 1
        retire_cnt = 2;
        tick(); idle(); #1;
        chk("clamp_empty", 32'(empty), 1);
        chk("clamp_vld", 32'(upd0_vld), 0);
        chk("clamp_free", 32'(free_cnt), 64);
        chk("clamp_head", 32'(upd0_WQ), 12);

        // retire_cnt=3 behaves as 2
        alloc0_req = 1; alloc1_req = 1; tick();
        alloc1_req = 0; tick(); idle();
        retire_cnt = 3;
        tick(); idle(); #1;
        chk("ret3_free", 32'(free_cnt), 63);
        chk("ret3_head", 32'(upd0_WQ), 14);
        chk("ret3_vld", 32'({upd0_vld, upd1_vld}), 2'b10);

        // Alloc and retire in the same cycle net out
        alloc0_req = 1; retire_cnt = 1;
        tick(); idle(); #1;
        chk("net_free", 32'(free_cnt), 63);
        chk("net_head", 32'(upd0_WQ), 15);
        chk("net_wen", 32'(wrt0_en), 1);

        // Asynchronous reset mid-operation
        #2 rst = 0; #1;
        chk("arst_free", 32'(free_cnt), 64);
        chk("arst_head", 32'(upd0_WQ), 0);
        chk("arst_wen", 32'(wrt0_en), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stq_wq_alloc.md
Name: stq_wq_alloc

Overview:
- Store-queue WQ slot allocator and retire-pointer tracker. Sits directly upstream of the 64-entry store-queue address-data side array.
- Hands out up to 2 in-order WQ indices per cycle to dispatching stores, and drives the array's two write ports one cycle later.
- Retires up to 2 oldest entries per cycle and presents the two oldest WQ indices on the array's read ports.
- Tracks occupancy, full/empty and flush rollback.

Parameters:
- DEPTH, 64, number of WQ entries; power of two, must match the array depth.
- WQW, 6, WQ index width, equal to log2(DEPTH).
- ADW, 5, adata width.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- alloc0_req  in  1  store 0 wants a WQ slot
- alloc0_adata  in  ADW  adata for store 0
- alloc1_req  in  1  store 1 wants a WQ slot
- alloc1_adata  in  ADW  adata for store 1
- alloc_stall  out  1  requests not granted this cycle
- alloc0_WQ  out  WQW  slot granted to store 0 (same cycle)
- alloc1_WQ  out  WQW  slot granted to store 1 (same cycle)
- wrt0_en, wrt1_en  out  1  registered write enables to the array
- wrt0_WQ, wrt1_WQ  out  WQW  registered write indices
- wrt0_adata, wrt1_adata  out  ADW  registered write data
- retire_cnt  in  2  entries retired this cycle (0..2)
- upd0_WQ  out  WQW  oldest entry index (head)
- upd1_WQ  out  WQW  second-oldest index (head+1)
- upd0_vld, upd1_vld  out  1  count>=1, count>=2
- flush  in  1  discard all unretired allocations
- free_cnt  out  WQW+1  free entries, 0..DEPTH
- full, empty  out  1  count==DEPTH, count==0

Behaviour:
- State: head[WQW-1:0], tail[WQW-1:0], count[WQW:0], plus one write-pipeline register stage.
- Reset values: head=tail=0, count=0, all wrt*_en=0, wrt WQ/adata=0. Derived outputs at reset: free_cnt=DEPTH, empty=1, full=0, upd*_vld=0, upd0_WQ=0, upd1_WQ=1.
- Request count: nreq = alloc0_req + alloc1_req.
- Stall: alloc_stall = nreq > free_cnt, computed combinationally from registered count. Allocation is all-or-nothing; on stall neither store is granted.
- Slot compaction: the first active requester (0 before 1) gets tail, the second gets tail+1. If only alloc1_req is asserted, alloc1_WQ=tail. alloc*_WQ of non-requesting ports is don't-care.
- Grant: nalloc = stall ? 0 : nreq. tail advances by nalloc mod DEPTH (6-bit wrap 63->0).
- Write latency: 1 cycle. In cycle N+1, wrtK_en/WQ/adata carry the cycle-N grant. Grant order maps to wrt0 then wrt1. With a single grant, only wrt0_en=1.
- Retire: nret = min(retire_cnt, count); larger values are clamped, never underflow. retire_cnt=3 is treated as 2. head advances by nret mod DEPTH.
- Count update: count_next = count + nalloc - nret; alloc and retire in the same cycle net out.
- Full with simultaneous retire: the stall still uses the pre-retire count (no same-cycle bypass).
- Flush has priority:
  - Retire is applied first, then tail<=head_next and count<=0.
  - Same-cycle allocation is dropped.
  - wrt*_en is forced 0 in the next cycle.
  - A write already registered from the prior cycle still issues (its data is stale-harmless).
- Reset mid-operation: immediate asynchronous clear of all state and the pipeline register.

Optional Feature:
- Macro: STQ_WQ_PARTIAL_FLUSH_EN.
- With the macro:
  - Extra input flush_WQ[WQW-1:0].
  - On flush, tail<=flush_WQ and count<=(flush_WQ - head_next) mod DEPTH.
  - Entries older than flush_WQ survive.
  - flush_WQ==head_next is equivalent to a full flush.
- Without the macro: no flush_WQ port; flush discards everything as described in Behaviour.

Decomposition:
- Shared store-queue package holds:
  - STQ_DEPTH=64, STQ_WQW=6, STQ_ADW=5.
  - A wq_t typedef (6-bit index) and an adata_t typedef (5-bit).
- One natural sub-module: stq_wq_ptr, a modular pointer with advance-by-0/1/2 and wrap, instantiated for head and tail.

Test Plan:
- Reset, then alloc0_req+alloc1_req with adata 5'h03/5'h1C. Expect: alloc0_WQ=0, alloc1_WQ=1; next cycle wrt0_en=wrt1_en=1, WQ 0/1, adata 03/1C; free_cnt=62.
- Only alloc1_req asserted. Expect: alloc1_WQ=tail, next cycle wrt0_en=1 carrying alloc1_adata, wrt1_en=0.
- Fill to count=63, then request 2. Expect: alloc_stall=1, no write. Request 1 instead: grant WQ=63, full=1, tail wraps to 0.
- Count=64 with retire_cnt=2 and a 2-request in the same cycle. Expect: stall, count=62, upd0_WQ advances by 2 mod 64.
- Count=5, head=10, flush+retire_cnt=1+alloc0_req. Expect: head=11, tail=11, count=0, empty=1, no wrt_en next cycle.
- Count=1, retire_cnt=2. Expect: nret=1, count=0, upd0_vld=0, no underflow.
